// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// Holds the FSM state enum, access-size enum, funct3 encodings and the
// MemRead/MemWrite bit positions within the MEM control field.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } lsu_state_e;

   typedef enum logic [1:0] {
      BYTE = 2'd0,
      HALF = 2'd1,
      WORD = 2'd2
   } lsu_size_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int MEMREAD_BIT  = 1;
   localparam int MEMWRITE_BIT = 0;

   // Any funct3 outside the byte/half encodings behaves as a full word.
   function automatic lsu_size_e decodeSize(input logic [2:0] f3);
      case (f3)
         F3_B, F3_BU: return BYTE;
         F3_H, F3_HU: return HALF;
         default:     return WORD;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit.
// Store side: positions store data on byte lanes and builds the strobes.
// Load side: shifts the read word down to the addressed byte and extends.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  stOff_i,
   input  lsu_size_e   stSize_i,
   input  logic [31:0] stData_i,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o,
   input  logic [1:0]  ldOff_i,
   input  lsu_size_e   ldSize_i,
   input  logic        ldSigned_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] ldData_o
);

   logic [31:0] rdataShifted;

   // Replicate the store value across the word so every lane carries it,
   // and let the strobes pick which lanes memory actually writes.
   always_comb begin
      wstrb_o = 4'b1111;
      wdata_o = stData_i;
      case (stSize_i)
         BYTE: begin
            wstrb_o = 4'b0001 << stOff_i;
            wdata_o = {4{stData_i[7:0]}};
         end
         HALF: begin
            wstrb_o = 4'b0011 << stOff_i;
            wdata_o = {2{stData_i[15:0]}};
         end
         default: begin
            wstrb_o = 4'b1111;
            wdata_o = stData_i;
         end
      endcase
   end

   // Bring the addressed byte to bit 0, then sign- or zero-extend by size.
   always_comb begin
      rdataShifted = rdata_i >> {ldOff_i, 3'b000};
      ldData_o     = rdataShifted;
      case (ldSize_i)
         BYTE:    ldData_o = {{24{ldSigned_i & rdataShifted[7]}}, rdataShifted[7:0]};
         HALF:    ldData_o = {{16{ldSigned_i & rdataShifted[15]}}, rdataShifted[15:0]};
         default: ldData_o = rdataShifted;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: runs one data-memory transaction per load or
// store over a req/gnt/rvalid handshake and stalls the pipeline meanwhile.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When defined, misaligned
// half/word accesses pulse mis_err and are not issued; otherwise the
// offending low address bits are cleared and the access proceeds.
module mem_lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        MEM_M,
   input  logic [31:0]       MEM_ALU_out,
   input  logic [31:0]       MEM_WriteDatain,
   input  logic [31:0]       MEM_instruction,
   input  logic              pipe_hold,
   output logic              dm_req,
   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [3:0]        dm_wstrb,
   output logic [31:0]       dm_wdata,
   input  logic              dm_gnt,
   input  logic              dm_rvalid,
   input  logic [31:0]       dm_rdata,
   output logic [31:0]       ld_data,
   output logic              mem_stall,
   output logic              mis_err
);

   lsu_state_e        state_q, state_d;
   logic              dmReq_q, dmReq_d;
   logic              dmWe_q, dmWe_d;
   logic [ADDR_W-1:0] dmAddr_q, dmAddr_d;
   logic [3:0]        dmWstrb_q, dmWstrb_d;
   logic [31:0]       dmWdata_q, dmWdata_d;
   logic [31:0]       ldData_q, ldData_d;
   logic [1:0]        ldOff_q, ldOff_d;
   lsu_size_e         ldSize_q, ldSize_d;
   logic              ldSigned_q, ldSigned_d;

   logic [2:0]        funct3;
   lsu_size_e         opSize;
   logic              opSigned;
   logic              opPending;
   logic              opWrite;
   logic              misaligned;
   logic              opLegal;
   logic [31:0]       effAddr;
   logic [3:0]        alignWstrb;
   logic [31:0]       alignWdata;
   logic [31:0]       alignLdData;
   logic              unusedInstrBits;

   assign funct3          = MEM_instruction[14:12];
   assign opSize          = decodeSize(funct3);
   assign opSigned        = ~funct3[2];
   assign opPending       = (MEM_M != 2'b00);
   assign opWrite         = MEM_M[MEMWRITE_BIT] & ~MEM_M[MEMREAD_BIT];
   assign unusedInstrBits = ^{MEM_instruction[31:15], MEM_instruction[11:0]};

`ifdef LSU_MISALIGN_TRAP_EN
   // Misaligned accesses are trapped, so the address passes through as-is.
   always_comb begin
      effAddr    = MEM_ALU_out;
      misaligned = ((opSize == HALF) && MEM_ALU_out[0]) ||
                   ((opSize == WORD) && (MEM_ALU_out[1:0] != 2'b00));
   end
`else
   // Without trapping, clear the low bits a half or word cannot use.
   always_comb begin
      effAddr    = MEM_ALU_out;
      misaligned = 1'b0;
      if (opSize == HALF) begin
         effAddr[0] = 1'b0;
      end else if (opSize == WORD) begin
         effAddr[1:0] = 2'b00;
      end
   end
`endif

   assign opLegal = opPending & ~misaligned;

   lsu_align uAlign (
      .stOff_i    (effAddr[1:0]),
      .stSize_i   (opSize),
      .stData_i   (MEM_WriteDatain),
      .wstrb_o    (alignWstrb),
      .wdata_o    (alignWdata),
      .ldOff_i    (ldOff_q),
      .ldSize_i   (ldSize_q),
      .ldSigned_i (ldSigned_q),
      .rdata_i    (dm_rdata),
      .ldData_o   (alignLdData)
   );

   // Next-state and stall logic. Bus fields are loaded on the IDLE->REQ
   // transition and then held; the load offset/size/sign are captured at
   // the same time so the response can be extracted without relying on
   // the EX/MEM register staying frozen.
   always_comb begin
      state_d    = state_q;
      dmReq_d    = dmReq_q;
      dmWe_d     = dmWe_q;
      dmAddr_d   = dmAddr_q;
      dmWstrb_d  = dmWstrb_q;
      dmWdata_d  = dmWdata_q;
      ldData_d   = ldData_q;
      ldOff_d    = ldOff_q;
      ldSize_d   = ldSize_q;
      ldSigned_d = ldSigned_q;
      mem_stall  = 1'b0;
      case (state_q)
         IDLE: begin
            if (opLegal) begin
               mem_stall  = 1'b1;
               state_d    = REQ;
               dmReq_d    = 1'b1;
               dmWe_d     = opWrite;
               dmAddr_d   = ADDR_W'({effAddr[31:2], 2'b00});
               dmWstrb_d  = opWrite ? alignWstrb : 4'b0000;
               dmWdata_d  = opWrite ? alignWdata : 32'h0;
               ldOff_d    = effAddr[1:0];
               ldSize_d   = opSize;
               ldSigned_d = opSigned;
            end
         end
         REQ: begin
            mem_stall = 1'b1;
            if (dm_gnt) begin
               state_d = WAIT;
               dmReq_d = 1'b0;
            end
         end
         WAIT: begin
            mem_stall = 1'b1;
            if (dm_rvalid) begin
               state_d = DONE;
               if (!dmWe_q) begin
                  ldData_d = alignLdData;
               end
            end
         end
         DONE: begin
            if (!pipe_hold) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and bus registers; reset aborts any in-flight access.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         dmReq_q    <= 1'b0;
         dmWe_q     <= 1'b0;
         dmAddr_q   <= '0;
         dmWstrb_q  <= 4'b0000;
         dmWdata_q  <= 32'h0;
         ldData_q   <= 32'h0;
         ldOff_q    <= 2'b00;
         ldSize_q   <= WORD;
         ldSigned_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         dmReq_q    <= dmReq_d;
         dmWe_q     <= dmWe_d;
         dmAddr_q   <= dmAddr_d;
         dmWstrb_q  <= dmWstrb_d;
         dmWdata_q  <= dmWdata_d;
         ldData_q   <= ldData_d;
         ldOff_q    <= ldOff_d;
         ldSize_q   <= ldSize_d;
         ldSigned_q <= ldSigned_d;
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic misErr_q, misErr_d;

   // A rejected access in IDLE raises a one-cycle error pulse.
   always_comb begin
      misErr_d = (state_q == IDLE) && opPending && misaligned;
   end

   // Error pulse register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         misErr_q <= 1'b0;
      end else begin
         misErr_q <= misErr_d;
      end
   end

   assign mis_err = misErr_q;
`else
   assign mis_err = 1'b0;
`endif

   assign dm_req   = dmReq_q;
   assign dm_we    = dmWe_q;
   assign dm_addr  = dmAddr_q;
   assign dm_wstrb = dmWstrb_q;
   assign dm_wdata = dmWdata_q;
   assign ld_data  = ldData_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: a table of directed transactions with
// hand-computed results, plus hand-written pipe_hold and mid-access reset
// sequences. Honours LSU_MISALIGN_TRAP_EN for the misaligned-word vector.
module tb_mem_lsu;

   typedef struct {
      logic [1:0]  memM;
      logic [2:0]  funct3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          gntDelay;
      int          rvDelay;
      logic        expReq;
      logic        expWe;
      logic [31:0] expAddr;
      logic [3:0]  expWstrb;
      logic [31:0] expWdata;
      int          expStall;
      logic [31:0] expLd;
      int          expMis;
   } vec_t;

   logic        clk;
   logic        rst;
   logic [1:0]  MEM_M;
   logic [31:0] MEM_ALU_out;
   logic [31:0] MEM_WriteDatain;
   logic [31:0] MEM_instruction;
   logic        pipe_hold;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [3:0]  dm_wstrb;
   logic [31:0] dm_wdata;
   logic        dm_gnt;
   logic        dm_rvalid;
   logic [31:0] dm_rdata;
   logic [31:0] ld_data;
   logic        mem_stall;
   logic        mis_err;

   int testsRun = 0;
   int failures = 0;
   vec_t vecs[12];

   mem_lsu #(.ADDR_W(32)) dut (
      .clk             (clk),
      .rst             (rst),
      .MEM_M           (MEM_M),
      .MEM_ALU_out     (MEM_ALU_out),
      .MEM_WriteDatain (MEM_WriteDatain),
      .MEM_instruction (MEM_instruction),
      .pipe_hold       (pipe_hold),
      .dm_req          (dm_req),
      .dm_we           (dm_we),
      .dm_addr         (dm_addr),
      .dm_wstrb        (dm_wstrb),
      .dm_wdata        (dm_wdata),
      .dm_gnt          (dm_gnt),
      .dm_rvalid       (dm_rvalid),
      .dm_rdata        (dm_rdata),
      .ld_data         (ld_data),
      .mem_stall       (mem_stall),
      .mis_err         (mis_err)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something upstream never returns.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] mkInstr(input logic [2:0] f3);
      return {17'd0, f3, 5'd0, 7'h03};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Runs one table entry from just after a rising edge, acting as the
   // memory (grant/rvalid after the programmed delays) and as the pipeline
   // (the op is withdrawn on the first edge where the LSU is not stalling).
   task automatic applyStimulus(input int idx, input vec_t v);
      int   reqCyc = 0;
      int   waitCyc = 0;
      int   stallCyc = 0;
      int   misCnt = 0;
      int   tail = 0;
      logic granted = 1'b0;
      logic responded = 1'b0;
      logic sawReq = 1'b0;
      logic cleared = 1'b0;
      logic done = 1'b0;
      logic stallNow;
      logic [31:0] capAddr = 32'h0;
      logic [31:0] capWdata = 32'h0;
      logic [3:0]  capWstrb = 4'h0;
      logic        capWe = 1'b0;

      MEM_M           = v.memM;
      MEM_ALU_out     = v.addr;
      MEM_WriteDatain = v.wdata;
      MEM_instruction = mkInstr(v.funct3);
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         @(negedge clk);
         stallNow = mem_stall;
         if (mem_stall) stallCyc++;
         if (mis_err) misCnt++;
         if (dm_req) begin
            if (!sawReq) begin
               sawReq   = 1'b1;
               capAddr  = dm_addr;
               capWdata = dm_wdata;
               capWstrb = dm_wstrb;
               capWe    = dm_we;
            end
            if (reqCyc == v.gntDelay) begin
               dm_gnt  = 1'b1;
               granted = 1'b1;
            end
            reqCyc++;
         end else if (granted && !responded) begin
            if (waitCyc == v.rvDelay - 1) begin
               dm_rvalid = 1'b1;
               dm_rdata  = v.rdata;
               responded = 1'b1;
            end
            waitCyc++;
         end
         if (cleared) begin
            tail++;
            if (tail >= 2) done = 1'b1;
         end
         @(posedge clk);
         #1;
         dm_gnt    = 1'b0;
         dm_rvalid = 1'b0;
         if (!stallNow && !cleared) begin
            MEM_M   = 2'b00;
            cleared = 1'b1;
         end
      end
      checkOutput($sformatf("v%0d completed", idx), {31'd0, done}, 32'd1);
      checkOutput($sformatf("v%0d dm_req seen", idx), {31'd0, sawReq}, {31'd0, v.expReq});
      if (v.expReq) begin
         checkOutput($sformatf("v%0d dm_addr", idx), capAddr, v.expAddr);
         checkOutput($sformatf("v%0d dm_wstrb", idx), {28'd0, capWstrb}, {28'd0, v.expWstrb});
         checkOutput($sformatf("v%0d dm_we", idx), {31'd0, capWe}, {31'd0, v.expWe});
         checkOutput($sformatf("v%0d req cycles", idx), reqCyc, v.gntDelay + 1);
         if (v.expWe) begin
            checkOutput($sformatf("v%0d dm_wdata", idx), capWdata, v.expWdata);
         end
      end
      checkOutput($sformatf("v%0d stall cycles", idx), stallCyc, v.expStall);
      checkOutput($sformatf("v%0d ld_data", idx), ld_data, v.expLd);
      checkOutput($sformatf("v%0d mis_err pulses", idx), misCnt, v.expMis);
   endtask

   // Load completes, then pipe_hold keeps the unit in DONE for 4 cycles:
   // no re-issue, no stall, result held.
   task automatic runHoldSequence();
      int reqSeen = 0;
      int stallSeen = 0;
      int ldBad = 0;
      MEM_M           = 2'b10;
      MEM_ALU_out     = 32'h200;
      MEM_instruction = mkInstr(3'b010);
      @(negedge clk);
      checkOutput("hold idle stall", {31'd0, mem_stall}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("hold dm_req", {31'd0, dm_req}, 32'd1);
      dm_gnt = 1'b1;
      @(posedge clk); #1;
      dm_gnt = 1'b0;
      @(negedge clk);
      dm_rvalid = 1'b1;
      dm_rdata  = 32'h55AA55AA;
      @(posedge clk); #1;
      dm_rvalid = 1'b0;
      pipe_hold = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (dm_req) reqSeen++;
         if (mem_stall) stallSeen++;
         if (ld_data !== 32'h55AA55AA) ldBad++;
         @(posedge clk); #1;
      end
      pipe_hold = 1'b0;
      checkOutput("hold no reissue", reqSeen, 0);
      checkOutput("hold stall low", stallSeen, 0);
      checkOutput("hold ld_data changes", ldBad, 0);
      checkOutput("hold ld_data", ld_data, 32'h55AA55AA);
      @(negedge clk);
      checkOutput("hold release stall", {31'd0, mem_stall}, 32'd0);
      @(posedge clk); #1;
      MEM_M = 2'b00;
      @(negedge clk);
      checkOutput("hold after dm_req", {31'd0, dm_req}, 32'd0);
      @(posedge clk); #1;
   endtask

   // Reset lands while a load waits for its response; the late rvalid
   // that follows must not touch ld_data.
   task automatic runResetSequence();
      MEM_M           = 2'b10;
      MEM_ALU_out     = 32'h300;
      MEM_instruction = mkInstr(3'b010);
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("rst seq dm_req", {31'd0, dm_req}, 32'd1);
      dm_gnt = 1'b1;
      @(posedge clk); #1;
      dm_gnt = 1'b0;
      @(negedge clk);
      checkOutput("rst seq wait stall", {31'd0, mem_stall}, 32'd1);
      rst   = 1'b0;
      MEM_M = 2'b00;
      #1;
      checkOutput("rst seq stall", {31'd0, mem_stall}, 32'd0);
      checkOutput("rst seq ld_data", ld_data, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      dm_rvalid = 1'b1;
      dm_rdata  = 32'hBAD0BAD0;
      @(posedge clk); #1;
      dm_rvalid = 1'b0;
      @(negedge clk);
      checkOutput("late rvalid ld_data", ld_data, 32'h0);
      checkOutput("late rvalid stall", {31'd0, mem_stall}, 32'd0);
      checkOutput("late rvalid dm_req", {31'd0, dm_req}, 32'd0);
      @(posedge clk); #1;
   endtask

   // Main sequence: reset state, table of transactions, corner sequences.
   initial begin
      vecs[0]  = '{2'b01, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0, 1, 1'b1, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 3, 32'h0,        0};
      vecs[1]  = '{2'b01, 3'b000, 32'h103, 32'h123456A5, 32'h0,        0, 1, 1'b1, 1'b1, 32'h100, 4'h8, 32'hA5A5A5A5, 3, 32'h0,        0};
      vecs[2]  = '{2'b10, 3'b000, 32'h102, 32'h0,        32'h00800000, 0, 1, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0,        3, 32'hFFFFFF80, 0};
      vecs[3]  = '{2'b10, 3'b100, 32'h102, 32'h0,        32'h00800000, 0, 1, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0,        3, 32'h00000080, 0};
      vecs[4]  = '{2'b10, 3'b001, 32'h102, 32'h0,        32'h80010000, 2, 3, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0,        7, 32'hFFFF8001, 0};
      vecs[5]  = '{2'b01, 3'b001, 32'h102, 32'h0000BEEF, 32'h0,        0, 1, 1'b1, 1'b1, 32'h100, 4'hC, 32'hBEEFBEEF, 3, 32'hFFFF8001, 0};
      vecs[6]  = '{2'b10, 3'b101, 32'h100, 32'h0,        32'h1234F00D, 1, 2, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0,        5, 32'h0000F00D, 0};
      vecs[7]  = '{2'b10, 3'b010, 32'h104, 32'h0,        32'hCAFEF00D, 0, 1, 1'b1, 1'b0, 32'h104, 4'h0, 32'h0,        3, 32'hCAFEF00D, 0};
      vecs[8]  = '{2'b11, 3'b000, 32'h101, 32'h0,        32'h0000AB00, 0, 1, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0,        3, 32'hFFFFFFAB, 0};
      vecs[9]  = '{2'b10, 3'b011, 32'h108, 32'h0,        32'h87654321, 0, 1, 1'b1, 1'b0, 32'h108, 4'h0, 32'h0,        3, 32'h87654321, 0};
      vecs[10] = '{2'b10, 3'b000, 32'h103, 32'h0,        32'h7F000000, 0, 1, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0,        3, 32'h0000007F, 0};
`ifdef LSU_MISALIGN_TRAP_EN
      vecs[11] = '{2'b10, 3'b010, 32'h101, 32'h0,        32'h11223344, 0, 1, 1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        0, 32'h0000007F, 1};
`else
      vecs[11] = '{2'b10, 3'b010, 32'h101, 32'h0,        32'h11223344, 0, 1, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0,        3, 32'h11223344, 0};
`endif

      rst             = 1'b0;
      MEM_M           = 2'b00;
      MEM_ALU_out     = 32'h0;
      MEM_WriteDatain = 32'h0;
      MEM_instruction = 32'h0;
      pipe_hold       = 1'b0;
      dm_gnt          = 1'b0;
      dm_rvalid       = 1'b0;
      dm_rdata        = 32'h0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset dm_req", {31'd0, dm_req}, 32'd0);
      checkOutput("reset dm_we", {31'd0, dm_we}, 32'd0);
      checkOutput("reset dm_addr", dm_addr, 32'h0);
      checkOutput("reset dm_wstrb", {28'd0, dm_wstrb}, 32'd0);
      checkOutput("reset dm_wdata", dm_wdata, 32'h0);
      checkOutput("reset ld_data", ld_data, 32'h0);
      checkOutput("reset mis_err", {31'd0, mis_err}, 32'd0);
      checkOutput("reset mem_stall", {31'd0, mem_stall}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      for (int i = 0; i < 12; i++) begin
         applyStimulus(i, vecs[i]);
      end

      runHoldSequence();
      runResetSequence();

      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end

endmodule
